ultrasound_echo_emulator: RTL and testbench
===========================================

# ultrasound_echo_emulator

Cycle-accurate behavioural stand-in for one HC-SR04 ultrasound module. It answers the trigger/echo/power interface driven by the rover location calculator. It accepts a trigger pulse, waits the acoustic burst delay, then drives an echo pulse whose width encodes a programmed distance. It also reproduces the no-target timeout and the "stuck until power cycled" failure. It sits on the bench side, or on a second FPGA, so the calculator can be exercised without physical sensors.

## Interface
Parameters:
- TRIGGER_MIN, 270: minimum trigger-high width in clocks (10 us at 27 MHz).
- ECHO_DELAY, 12150: clocks from trigger fall to echo rise (450 us).
- CLOCKS_PER_INCH, 3996: echo clocks per inch (148 us × 27).
- NO_ECHO_CLOCKS, 1026000: echo width when no target is present (38 ms).
- HOLDOFF, 27000: dead time after echo falls, during which triggers are ignored.

Ports:
- clock  in  1  system clock, 27 MHz.
- reset  in  1  reset, synchronous, active-high.
- power  in  1  sensor supply enable; 0 = module unpowered.
- trigger  in  1  trigger from the calculator; asynchronous, 2-flop synchronised.
- distance_inches  in  8  target distance, latched at trigger fall.
- target_present  in  1  0 = emit the no-target echo, latched at trigger fall.
- stick_enable  in  1  1 = a latched distance of 0 enters STUCK.
- echo  out  1  echo pulse to the calculator.
- busy  out  1  high in any state other than IDLE and OFF.
- state  out  3  current FSM state, for debug.

## Operation
States:
- OFF
- IDLE
- TRIG_HIGH
- DELAY
- ECHO
- STUCK
- HOLDOFF

Transitions:
- Reset: state=IDLE; echo=0; busy=0; all counters=0. Then OFF if power=0.
- Any state with power=0 → OFF, echo=0. OFF with power=1 → IDLE, counters cleared.
- IDLE, synced trigger=1 → TRIG_HIGH, trig_count=1.
- TRIG_HIGH: while trigger stays high, trig_count increments and saturates at TRIGGER_MIN.
  - On fall with trig_count ≥ TRIGGER_MIN: latch distance and target_present, then go to DELAY with delay_count=0.
  - On fall with trig_count < TRIGGER_MIN: return to IDLE with no echo.
- DELAY, after ECHO_DELAY cycles:
  - target_present=0 → ECHO with width=NO_ECHO_CLOCKS.
  - latched distance=0 and stick_enable=1 → STUCK.
  - latched distance=0 and stick_enable=0 → ECHO with width=1.
  - otherwise → ECHO with width=distance×CLOCKS_PER_INCH.
- ECHO: echo=1 for exactly width cycles, then echo=0 → HOLDOFF.
- STUCK: echo=1 indefinitely; only power=0 exits (to OFF).
- HOLDOFF: after HOLDOFF cycles → IDLE.

Ignore rules:
- Trigger activity in DELAY, ECHO, STUCK and HOLDOFF is ignored.
- Changes to distance_inches and target_present after the latch do not affect the current echo.

Arithmetic and widths:
- width = distance × CLOCKS_PER_INCH, computed as an unsigned product and registered once, on entry to ECHO.
- width and echo_count are 20 bits. The maximum, 255×3996 = 1,018,980, fits.
- delay_count is 14 bits. trig_count is 9 bits. holdoff_count is 15 bits.

## Timing
- Trigger path: 2-cycle synchroniser latency, so state reacts 2 clocks after the input edge.
- Echo rise follows the raw trigger fall by 2 + ECHO_DELAY + 1 clocks.
- Echo high time equals width exactly, with no ±1 error.
- echo, busy and state are registered outputs.
- power=0 forces echo=0 by the next clock edge.
- Power restored mid-sequence restarts from IDLE; no partial echo is ever emitted.
- reset has priority over power. Reset mid-echo drops echo on the next edge.
- Simultaneous trigger fall and power drop: power wins, go to OFF.

## Structure
- Shared package ultrasound_pkg holds:
  - CLOCKS_PER_US, CLOCKS_PER_INCH, NO_ECHO_CLOCKS and TRIGGER_MIN, also consumed by the calculator;
  - the 3-bit state encoding localparams for this block.
- One sub-module: sync_2ff, a generic 2-flop synchroniser for trigger.
- The FSM, counters and multiply stay in the top module.

## Test plan
Test parameters: TRIGGER_MIN=5, ECHO_DELAY=4, CLOCKS_PER_INCH=3, NO_ECHO_CLOCKS=50, HOLDOFF=6.
- Trigger high 5 clocks with distance=7 → echo rises 7 clocks after the trigger fall and stays high exactly 21 clocks; busy drops 6 clocks after echo falls.
- Trigger high 4 clocks → no echo; state back to IDLE.
- target_present=0 → echo high 50 clocks. distance changed to 2 during DELAY → width stays per the latched value.
- distance=0 with stick_enable=1 → echo stays high for 1000 clocks. Then power=0 for 3 clocks → echo=0 next edge; a new trigger with distance=1 gives a 3-clock echo.
- Second trigger during ECHO and during HOLDOFF → ignored; a trigger after HOLDOFF → normal echo.
- reset asserted mid-ECHO → echo=0, busy=0, state=IDLE on the next edge.

Source files
------------

// File: rtl/ultrasound_pkg.sv
// Shared constants for the HC-SR04 sensor path: timing at 27 MHz and state encodings.
package ultrasound_pkg;

  localparam int unsigned CLOCKS_PER_US   = 27;
  localparam int unsigned CLOCKS_PER_INCH = 148 * CLOCKS_PER_US;
  localparam int unsigned NO_ECHO_CLOCKS  = 38000 * CLOCKS_PER_US;
  localparam int unsigned TRIGGER_MIN     = 10 * CLOCKS_PER_US;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DIST_W  = 8;
  localparam int unsigned WIDTH_W = 20;
  localparam int unsigned DELAY_W = 14;
  localparam int unsigned TRIG_W  = 9;
  localparam int unsigned HOLD_W  = 15;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_OFF       = 3'd1;
  localparam logic [STATE_W-1:0] ST_TRIG_HIGH = 3'd2;
  localparam logic [STATE_W-1:0] ST_DELAY     = 3'd3;
  localparam logic [STATE_W-1:0] ST_ECHO      = 3'd4;
  localparam logic [STATE_W-1:0] ST_STUCK     = 3'd5;
  localparam logic [STATE_W-1:0] ST_HOLDOFF   = 3'd6;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages; the first may go metastable, the second resolves it.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasound_echo_emulator.sv
// Behavioural stand-in for one HC-SR04: trigger in, delayed distance-coded echo out.
module ultrasound_echo_emulator #(
  parameter int unsigned TRIGGER_MIN     = ultrasound_pkg::TRIGGER_MIN,
  parameter int unsigned ECHO_DELAY      = 12150,
  parameter int unsigned CLOCKS_PER_INCH = ultrasound_pkg::CLOCKS_PER_INCH,
  parameter int unsigned NO_ECHO_CLOCKS  = ultrasound_pkg::NO_ECHO_CLOCKS,
  parameter int unsigned HOLDOFF         = 27000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               power,
  input  logic                               trigger,
  input  logic [ultrasound_pkg::DIST_W-1:0]  distance_inches,
  input  logic                               target_present,
  input  logic                               stick_enable,
  output logic                               echo,
  output logic                               busy,
  output logic [ultrasound_pkg::STATE_W-1:0] state
);

  import ultrasound_pkg::*;

  localparam logic [WIDTH_W-1:0] CPI_C      = WIDTH_W'(CLOCKS_PER_INCH);
  localparam logic [WIDTH_W-1:0] NO_ECHO_C  = WIDTH_W'(NO_ECHO_CLOCKS);
  localparam logic [TRIG_W-1:0]  TRIG_MIN_C = TRIG_W'(TRIGGER_MIN);
  localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(ECHO_DELAY - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF - 1);

  logic                trigger_sync;
  logic [STATE_W-1:0]  state_next;
  logic [TRIG_W-1:0]   trig_count, trig_count_next;
  logic [DELAY_W-1:0]  delay_count, delay_count_next;
  logic [WIDTH_W-1:0]  echo_count, echo_count_next;
  logic [HOLD_W-1:0]   holdoff_count, holdoff_count_next;
  logic [WIDTH_W-1:0]  width, width_next;
  logic [DIST_W-1:0]   dist_lat, dist_lat_next;
  logic                target_lat, target_lat_next;
  logic                echo_d, busy_d;

  sync_2ff #(.WIDTH(1)) u_trigger_sync (
    .clock (clock),
    .reset (reset),
    .d     (trigger),
    .q     (trigger_sync)
  );

  // State, counters, latched target and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      echo          <= 1'b0;
      busy          <= 1'b0;
      trig_count    <= '0;
      delay_count   <= '0;
      echo_count    <= '0;
      holdoff_count <= '0;
      width         <= '0;
      dist_lat      <= '0;
      target_lat    <= 1'b0;
    end else begin
      state         <= state_next;
      echo          <= echo_d;
      busy          <= busy_d;
      trig_count    <= trig_count_next;
      delay_count   <= delay_count_next;
      echo_count    <= echo_count_next;
      holdoff_count <= holdoff_count_next;
      width         <= width_next;
      dist_lat      <= dist_lat_next;
      target_lat    <= target_lat_next;
    end
  end

  // Next state and next counter values; loss of power overrides everything.
  always_comb begin
    state_next         = state;
    trig_count_next    = trig_count;
    delay_count_next   = delay_count;
    echo_count_next    = echo_count;
    holdoff_count_next = holdoff_count;
    width_next         = width;
    dist_lat_next      = dist_lat;
    target_lat_next    = target_lat;

    if (!power || state == ST_OFF) begin
      state_next         = power ? ST_IDLE : ST_OFF;
      trig_count_next    = '0;
      delay_count_next   = '0;
      echo_count_next    = '0;
      holdoff_count_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger_sync) begin
            state_next      = ST_TRIG_HIGH;
            trig_count_next = TRIG_W'(1);
          end
        end
        ST_TRIG_HIGH: begin
          if (trigger_sync) begin
            if (trig_count < TRIG_MIN_C) trig_count_next = trig_count + 1'b1;
          end else if (trig_count >= TRIG_MIN_C) begin
            state_next       = ST_DELAY;
            delay_count_next = '0;
            dist_lat_next    = distance_inches;
            target_lat_next  = target_present;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (delay_count == DELAY_LAST) begin
            echo_count_next = WIDTH_W'(1);
            state_next      = ST_ECHO;
            if (!target_lat) begin
              width_next = NO_ECHO_C;
            end else if (dist_lat == '0) begin
              if (stick_enable) state_next = ST_STUCK;
              else              width_next = WIDTH_W'(1);
            end else begin
              width_next = WIDTH_W'(WIDTH_W'(dist_lat) * CPI_C);
            end
          end else begin
            delay_count_next = delay_count + 1'b1;
          end
        end
        ST_ECHO: begin
          if (echo_count == width) begin
            state_next         = ST_HOLDOFF;
            holdoff_count_next = '0;
          end else begin
            echo_count_next = echo_count + 1'b1;
          end
        end
        ST_STUCK: state_next = ST_STUCK;
        ST_HOLDOFF: begin
          if (holdoff_count == HOLD_LAST) state_next = ST_IDLE;
          else holdoff_count_next = holdoff_count + 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output values derived from the upcoming state, registered alongside it.
  always_comb begin
    echo_d = 1'b0;
    busy_d = 1'b0;
    if (state_next == ST_ECHO || state_next == ST_STUCK) echo_d = 1'b1;
    if (state_next != ST_IDLE && state_next != ST_OFF) busy_d = 1'b1;
  end

endmodule

// File: tb/tb_ultrasound_echo_emulator.sv
// Directed self-checking bench for ultrasound_echo_emulator with shortened timing.
module tb_ultrasound_echo_emulator;

  import ultrasound_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       power;
  logic       trigger;
  logic [7:0] distance_inches;
  logic       target_present;
  logic       stick_enable;
  logic       echo;
  logic       busy;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int rise, high, idle_n, highs;

  ultrasound_echo_emulator #(
    .TRIGGER_MIN     (5),
    .ECHO_DELAY      (4),
    .CLOCKS_PER_INCH (3),
    .NO_ECHO_CLOCKS  (50),
    .HOLDOFF         (6)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .power           (power),
    .trigger         (trigger),
    .distance_inches (distance_inches),
    .target_present  (target_present),
    .stick_enable    (stick_enable),
    .echo            (echo),
    .busy            (busy),
    .state           (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_trigger(input int n);
    trigger = 1'b1;
    step(n);
    trigger = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (echo !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    if (echo !== 1'b1) n = -1;
  endtask

  task automatic measure_high(input int limit, output int n);
    n = 0;
    while (echo === 1'b1 && n < limit) begin
      n++;
      step(1);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    if (busy !== 1'b0) n = -1;
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step(1);
      if (echo !== 1'b0) cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; power = 1'b0; trigger = 1'b0;
    distance_inches = 8'd0; target_present = 1'b1; stick_enable = 1'b0;
    step(2);
    chk("reset_state", 32'(state), 32'(ST_IDLE));
    chk("reset_echo", 32'(echo), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(1);
    chk("unpowered_off", 32'(state), 32'(ST_OFF));
    power = 1'b1;
    step(1);
    chk("power_up_idle", 32'(state), 32'(ST_IDLE));
    step(2);

    // distance 7: rise 7 clocks after fall, 21-clock echo, 6-clock holdoff
    distance_inches = 8'd7;
    pulse_trigger(5);
    wait_rise(rise);
    chk("d7_rise", 32'(rise), 32'd7);
    chk("d7_busy_in_echo", 32'(busy), 32'd1);
    measure_high(200, high);
    chk("d7_width", 32'(high), 32'd21);
    chk("d7_holdoff_state", 32'(state), 32'(ST_HOLDOFF));
    wait_idle(idle_n);
    chk("d7_holdoff_len", 32'(idle_n), 32'd6);
    chk("d7_idle", 32'(state), 32'(ST_IDLE));
    step(3);

    // short trigger: no echo
    pulse_trigger(4);
    watch(20, highs);
    chk("short_no_echo", 32'(highs), 32'd0);
    chk("short_idle", 32'(state), 32'(ST_IDLE));
    chk("short_busy", 32'(busy), 32'd0);

    // no target: 50-clock echo
    target_present = 1'b0;
    distance_inches = 8'd9;
    pulse_trigger(5);
    wait_rise(rise);
    chk("nt_rise", 32'(rise), 32'd7);
    measure_high(200, high);
    chk("nt_width", 32'(high), 32'd50);
    wait_idle(idle_n);
    chk("nt_holdoff_len", 32'(idle_n), 32'd6);
    step(3);

    // distance 4 latched; inputs changed during DELAY must not matter
    target_present = 1'b1;
    distance_inches = 8'd4;
    pulse_trigger(5);
    step(4);
    chk("latch_in_delay", 32'(state), 32'(ST_DELAY));
    distance_inches = 8'd2;
    target_present = 1'b0;
    wait_rise(rise);
    chk("latch_rise", 32'(rise), 32'd3);
    measure_high(200, high);
    chk("latch_width", 32'(high), 32'd12);
    wait_idle(idle_n);
    target_present = 1'b1;
    step(3);

    // distance 0 with stick: stuck high until power cycled
    distance_inches = 8'd0;
    stick_enable = 1'b1;
    pulse_trigger(5);
    wait_rise(rise);
    chk("stuck_rise", 32'(rise), 32'd7);
    measure_high(1000, high);
    chk("stuck_high_1000", 32'(high), 32'd1000);
    chk("stuck_still_high", 32'(echo), 32'd1);
    chk("stuck_state", 32'(state), 32'(ST_STUCK));
    power = 1'b0;
    step(1);
    chk("pwr_off_echo", 32'(echo), 32'd0);
    chk("pwr_off_state", 32'(state), 32'(ST_OFF));
    chk("pwr_off_busy", 32'(busy), 32'd0);
    step(2);
    power = 1'b1;
    step(1);
    chk("pwr_on_idle", 32'(state), 32'(ST_IDLE));
    distance_inches = 8'd1;
    stick_enable = 1'b0;
    pulse_trigger(5);
    wait_rise(rise);
    chk("d1_rise", 32'(rise), 32'd7);
    measure_high(200, high);
    chk("d1_width", 32'(high), 32'd3);
    wait_idle(idle_n);
    step(3);

    // distance 0 without stick: one-clock echo
    distance_inches = 8'd0;
    pulse_trigger(5);
    wait_rise(rise);
    chk("d0_rise", 32'(rise), 32'd7);
    measure_high(200, high);
    chk("d0_width", 32'(high), 32'd1);
    wait_idle(idle_n);
    step(3);

    // triggers during ECHO and HOLDOFF are ignored
    distance_inches = 8'd5;
    pulse_trigger(5);
    wait_rise(rise);
    chk("ign_rise", 32'(rise), 32'd7);
    step(2);
    pulse_trigger(5);
    measure_high(200, high);
    chk("ign_echo_rest", 32'(high), 32'd8);
    chk("ign_holdoff_state", 32'(state), 32'(ST_HOLDOFF));
    pulse_trigger(5);
    watch(20, highs);
    chk("ign_holdoff_no_echo", 32'(highs), 32'd0);
    chk("ign_idle", 32'(state), 32'(ST_IDLE));
    pulse_trigger(5);
    wait_rise(rise);
    chk("after_rise", 32'(rise), 32'd7);
    measure_high(200, high);
    chk("after_width", 32'(high), 32'd15);
    wait_idle(idle_n);
    chk("after_holdoff_len", 32'(idle_n), 32'd6);
    step(3);

    // reset mid-echo
    distance_inches = 8'd10;
    pulse_trigger(5);
    wait_rise(rise);
    chk("rst_rise", 32'(rise), 32'd7);
    step(5);
    reset = 1'b1;
    step(1);
    chk("rst_mid_echo", 32'(echo), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;
    step(2);
    chk("rst_after_idle", 32'(state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
